vram_fill_scroll_engine: RTL and testbench
==========================================

Name: vram_fill_scroll_engine

Overview:
Parametrised successor to the text-mode clear engine in the VRAM write path. Executes four commands against the character VRAM: full clear, single-line clear, rectangle fill and scroll-up by N rows.
- Uses a valid/ready write port with backpressure and a fixed-latency read port for the copy phase of a scroll.
- Sits between the console controller (command source) and the VRAM arbiter.

Parameters:
COLS, 80, characters per row
ROWS, 30, rows per screen
COL_W, 7, column index width; must satisfy COLS <= 2**COL_W
ROW_W, 5, row index width; must satisfy ROWS <= 2**ROW_W
DATA_W, 8, cell data width
RD_LAT, 1, VRAM read latency in cycles; must be >= 1

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
start  in  1  command strobe, sampled only when busy=0
cmd  in  2  0=FULL_CLEAR, 1=LINE_CLEAR, 2=RECT_FILL, 3=SCROLL_UP
fill_value  in  DATA_W  value written by clear, fill and scroll-vacated cells
x0,x1  in  COL_W  rectangle columns, inclusive (RECT_FILL only)
y0,y1  in  ROW_W  y0 = line index (LINE_CLEAR) or first rectangle row; y1 = last rectangle row
scroll_n  in  ROW_W  rows to scroll (SCROLL_UP only)
busy  out  1  command in progress
done  out  1  1-cycle completion pulse
err  out  1  1-cycle pulse, coincident with done, when the command was rejected
we  out  1  write request
waddr  out  ROW_W+COL_W  packed address {y,x}
wdata  out  DATA_W  write data
wready  in  1  write accepted when we && wready
re  out  1  1-cycle read request
raddr  out  ROW_W+COL_W  packed read address {y,x}
rdata  in  DATA_W  valid RD_LAT cycles after re

Behaviour:
- Reset values: busy=0, done=0, err=0, we=0, re=0, waddr=0, raddr=0, wdata=0; FSM returns to IDLE.
- Reset mid-command aborts immediately. No further we or re; done is not asserted.
- Command latching:
  - start with busy=0 at edge t latches cmd, fill_value and all geometry.
  - busy=1 from t+1.
  - Inputs may change afterwards without effect.
  - start while busy=1 is ignored.
- Validation, performed at latch time:
  - LINE_CLEAR with y0>=ROWS is rejected.
  - RECT_FILL with x0>x1, y0>y1, x1>=COLS or y1>=ROWS is rejected.
  - A rejected command gives busy=1 for exactly one cycle, then done=err=1 for one cycle, with no we or re.
- Write handshake:
  - we, waddr and wdata are held stable while we=1 && wready=0.
  - The cursor advances only on acceptance.
  - At most one write is accepted per cycle.
- Traversal:
  - Row-major: x increments to the region's last column, then wraps to the first column with y+1.
  - Exactly one write per cell; x never reaches COLS.
- FSM states: IDLE, FILL, RD_ISSUE, RD_WAIT, CP_WRITE, FINISH.
- FILL state, used by all clears and fills:
  - we=1 from t+1, with wdata=fill_value.
  - With wready held at 1, the command completes in cells+1 cycles after start.
  - On the final acceptance go to FINISH.
- Regions:
  - FULL_CLEAR covers rows 0..ROWS-1, cols 0..COLS-1.
  - LINE_CLEAR covers row y0, cols 0..COLS-1.
  - RECT_FILL covers x0..x1 by y0..y1.
- SCROLL_UP:
  - scroll_n=0 gives done after one busy cycle, with no accesses and err=0.
  - scroll_n>=ROWS executes exactly as FULL_CLEAR.
  - Otherwise, copy phase: for destination (x,y) over rows 0..ROWS-1-scroll_n:
    - RD_ISSUE: re=1 and raddr={y+scroll_n,x} for one cycle.
    - RD_WAIT: RD_LAT cycles.
    - CP_WRITE: capture rdata, present we with waddr={y,x}, hold until accepted.
    - Then advance and return to RD_ISSUE.
  - Each cell costs RD_LAT+2 cycles with wready=1.
  - Then a fill phase over rows ROWS-scroll_n..ROWS-1 with fill_value.
  - re is never asserted while we=1.
- FINISH: busy=0, done=1 for one cycle, then IDLE. start is accepted again in the cycle after done.
- Width rules:
  - y+scroll_n is computed at ROW_W+1 bits.
  - Row and column counters never exceed ROWS-1 and COLS-1.

Decomposition:
- Package vram_eng_pkg:
  - cmd_e enum (FULL_CLEAR, LINE_CLEAR, RECT_FILL, SCROLL_UP).
  - state_e enum.
  - Function pack_addr(y,x).
- Sub-module rect_walker:
  - Holds x and y bounds.
  - Inputs: load, advance.
  - Outputs: cur_x, cur_y, last (asserted at the final cell).
  - Reused for the copy, fill and rectangle walks.

Test Plan:
- FULL_CLEAR, fill_value=8'h20, wready=1: exactly 2400 writes at {0,0}..{29,79}. done 2401 cycles after start. No address with x=80.
- LINE_CLEAR y0=7, then LINE_CLEAR y0=30: first gives 80 writes on row 7. Second gives err=done=1 and zero writes.
- RECT_FILL x0=10,x1=12,y0=3,y1=4, fill=8'h2A, wready toggling 1/0: 6 writes in order {3,10},{3,11},{3,12},{4,10},{4,11},{4,12}. Address and data are stable across stalls.
- SCROLL_UP scroll_n=2 against a VRAM model preloaded with cell={y,x}-derived data, RD_LAT=2:
  - Rows 0..27 equal the old rows 2..29.
  - Rows 28..29 equal fill_value.
  - 2240 reads; re and we are never asserted together.
- SCROLL_UP scroll_n=0, then scroll_n=31: first gives done with no accesses. Second matches the FULL_CLEAR write sequence.
- Overlap and reset: start pulses during busy are ignored. rst asserted mid-RECT_FILL gives we=0 immediately and no done. A new start after reset executes normally.

Source files
------------

// File: rtl/vram_eng_pkg.sv
// Shared types and address packing for the VRAM fill/scroll engine.
package vram_eng_pkg;

    typedef enum logic [1:0] {
        FULL_CLEAR = 2'd0,
        LINE_CLEAR = 2'd1,
        RECT_FILL  = 2'd2,
        SCROLL_UP  = 2'd3
    } cmd_e;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FILL     = 3'd1,
        RD_ISSUE = 3'd2,
        RD_WAIT  = 3'd3,
        CP_WRITE = 3'd4,
        FINISH   = 3'd5
    } state_e;

    localparam int unsigned ADDR_FN_W = 32;

    // {y,x} packing; callers truncate to their own address width
    function automatic logic [ADDR_FN_W-1:0] pack_addr(input logic [15:0] y,
                                                       input logic [15:0] x,
                                                       input int unsigned col_w);
        return (ADDR_FN_W'(y) << col_w) | ADDR_FN_W'(x);
    endfunction

endpackage

// File: rtl/vram_fill_scroll_engine_if.sv
// Command and VRAM port bundle between console controller, engine and VRAM arbiter.
interface vram_fill_scroll_engine_if #(
    parameter int unsigned COL_W  = 7,
    parameter int unsigned ROW_W  = 5,
    parameter int unsigned DATA_W = 8
);
    logic                    start;
    logic [1:0]              cmd;
    logic [DATA_W-1:0]       fill_value;
    logic [COL_W-1:0]        x0, x1;
    logic [ROW_W-1:0]        y0, y1, scroll_n;
    logic                    busy, done, err;
    logic                    we, wready, re;
    logic [ROW_W+COL_W-1:0]  waddr, raddr;
    logic [DATA_W-1:0]       wdata, rdata;

    modport master (
        input  start, cmd, fill_value, x0, x1, y0, y1, scroll_n, wready, rdata,
        output busy, done, err, we, waddr, wdata, re, raddr
    );

    modport slave (
        output start, cmd, fill_value, x0, x1, y0, y1, scroll_n, wready, rdata,
        input  busy, done, err, we, waddr, wdata, re, raddr
    );
endinterface

// File: rtl/rect_walker.sv
// Row-major cursor over an inclusive rectangle; steps once per advance, flags the final cell.
module rect_walker #(
    parameter int unsigned COL_W = 7,
    parameter int unsigned ROW_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [COL_W-1:0] x_lo,
    input  logic [COL_W-1:0] x_hi,
    input  logic [ROW_W-1:0] y_lo,
    input  logic [ROW_W-1:0] y_hi,
    input  logic             advance,
    output logic [COL_W-1:0] cur_x,
    output logic [ROW_W-1:0] cur_y,
    output logic             last,
    output logic [COL_W-1:0] nxt_x_c,
    output logic [ROW_W-1:0] nxt_y_c
);
    logic [COL_W-1:0] xl_q, xh_q;
    logic [ROW_W-1:0] yh_q;

    always_comb begin
        nxt_x_c = COL_W'(cur_x + 1'b1);
        nxt_y_c = cur_y;
        if (cur_x == xh_q) begin
            nxt_x_c = xl_q;
            nxt_y_c = ROW_W'(cur_y + 1'b1);
        end
    end

    // the cursor is frozen on the final cell so it never leaves the region
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xl_q  <= '0;
            xh_q  <= '0;
            yh_q  <= '0;
            cur_x <= '0;
            cur_y <= '0;
            last  <= 1'b0;
        end else if (load) begin
            xl_q  <= x_lo;
            xh_q  <= x_hi;
            yh_q  <= y_hi;
            cur_x <= x_lo;
            cur_y <= y_lo;
            last  <= (x_lo == x_hi) && (y_lo == y_hi);
        end else if (advance && !last) begin
            cur_x <= nxt_x_c;
            cur_y <= nxt_y_c;
            last  <= (nxt_x_c == xh_q) && (nxt_y_c == yh_q);
        end
    end
endmodule

// File: rtl/vram_fill_scroll_engine.sv
// Clear, line clear, rectangle fill and scroll-up engine for the character VRAM write path.
module vram_fill_scroll_engine
    import vram_eng_pkg::*;
#(
    parameter int unsigned COLS   = 80,
    parameter int unsigned ROWS   = 30,
    parameter int unsigned COL_W  = 7,
    parameter int unsigned ROW_W  = 5,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    vram_fill_scroll_engine_if.master bus
);
    localparam int unsigned     AW     = ROW_W + COL_W;
    localparam int unsigned     LW     = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [COL_W-1:0] X_MAX = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] Y_MAX = ROW_W'(ROWS - 1);
    localparam logic [ROW_W:0]   ROWS_E = (ROW_W + 1)'(ROWS);
    localparam logic [COL_W:0]   COLS_E = (COL_W + 1)'(COLS);

    state_e            state;
    logic              busy_q, done_q, err_q, we_q, re_q, rej_q;
    logic [AW-1:0]     raddr_q;
    logic [DATA_W-1:0] wdata_q, fill_q;
    logic [ROW_W-1:0]  n_q;
    logic [LW-1:0]     wait_q;

    logic              w_load, w_adv, w_last;
    logic [COL_W-1:0]  w_xlo, w_xhi, cur_x, nxt_x_c;
    logic [ROW_W-1:0]  w_ylo, w_yhi, cur_y, nxt_y_c;

    cmd_e              cmd_c;
    logic [ROW_W:0]    n_ext_c, nq_ext_c;
    logic              line_bad_c, rect_bad_c, scroll_zero_c, scroll_full_c;
    logic              reject_c, no_op_c, copy_c;

    assign cmd_c         = cmd_e'(bus.cmd);
    assign n_ext_c       = {1'b0, bus.scroll_n};
    assign nq_ext_c      = {1'b0, n_q};
    assign line_bad_c    = ({1'b0, bus.y0} >= ROWS_E);
    assign rect_bad_c    = (bus.x0 > bus.x1) || (bus.y0 > bus.y1) ||
                           ({1'b0, bus.x1} >= COLS_E) || ({1'b0, bus.y1} >= ROWS_E);
    assign scroll_zero_c = (bus.scroll_n == '0);
    assign scroll_full_c = (n_ext_c >= ROWS_E);
    assign reject_c      = ((cmd_c == LINE_CLEAR) && line_bad_c) ||
                           ((cmd_c == RECT_FILL) && rect_bad_c);
    assign no_op_c       = reject_c || ((cmd_c == SCROLL_UP) && scroll_zero_c);
    assign copy_c        = (cmd_c == SCROLL_UP) && !scroll_zero_c && !scroll_full_c;

    // walker region select: command region at latch, vacated rows after the copy phase
    always_comb begin
        w_load = 1'b0;
        w_xlo  = '0;
        w_xhi  = X_MAX;
        w_ylo  = '0;
        w_yhi  = Y_MAX;
        w_adv  = bus.wready && !w_last && ((state == FILL) || (state == CP_WRITE));
        if (state == IDLE && bus.start && !no_op_c) begin
            w_load = 1'b1;
            case (cmd_c)
                LINE_CLEAR: begin
                    w_ylo = bus.y0;
                    w_yhi = bus.y0;
                end
                RECT_FILL: begin
                    w_xlo = bus.x0;
                    w_xhi = bus.x1;
                    w_ylo = bus.y0;
                    w_yhi = bus.y1;
                end
                SCROLL_UP: begin
                    if (!scroll_full_c) w_yhi = ROW_W'(ROWS_E - (ROW_W + 1)'(1) - n_ext_c);
                end
                default: ;
            endcase
        end else if (state == CP_WRITE && bus.wready && w_last) begin
            w_load = 1'b1;
            w_ylo  = ROW_W'(ROWS_E - nq_ext_c);
        end
    end

    rect_walker #(.COL_W(COL_W), .ROW_W(ROW_W)) u_walker (
        .clk     (clk),
        .rst     (rst),
        .load    (w_load),
        .x_lo    (w_xlo),
        .x_hi    (w_xhi),
        .y_lo    (w_ylo),
        .y_hi    (w_yhi),
        .advance (w_adv),
        .cur_x   (cur_x),
        .cur_y   (cur_y),
        .last    (w_last),
        .nxt_x_c (nxt_x_c),
        .nxt_y_c (nxt_y_c)
    );

    // command sequencer; rejected and empty commands spend one busy cycle in FINISH first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            rej_q   <= 1'b0;
            raddr_q <= '0;
            wdata_q <= '0;
            fill_q  <= '0;
            n_q     <= '0;
            wait_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        fill_q <= bus.fill_value;
                        n_q    <= bus.scroll_n;
                        busy_q <= 1'b1;
                        if (no_op_c) begin
                            rej_q <= reject_c;
                            state <= FINISH;
                        end else if (copy_c) begin
                            re_q    <= 1'b1;
                            raddr_q <= AW'(pack_addr(16'(bus.scroll_n), 16'(0), COL_W));
                            state   <= RD_ISSUE;
                        end else begin
                            we_q    <= 1'b1;
                            wdata_q <= bus.fill_value;
                            state   <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (bus.wready && w_last) begin
                        we_q   <= 1'b0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= FINISH;
                    end
                end
                RD_ISSUE: begin
                    re_q   <= 1'b0;
                    wait_q <= '0;
                    state  <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (wait_q == LW'(RD_LAT - 1)) begin
                        wdata_q <= bus.rdata;
                        we_q    <= 1'b1;
                        state   <= CP_WRITE;
                    end else begin
                        wait_q <= LW'(wait_q + 1'b1);
                    end
                end
                CP_WRITE: begin
                    if (bus.wready) begin
                        if (w_last) begin
                            wdata_q <= fill_q;
                            state   <= FILL;
                        end else begin
                            we_q    <= 1'b0;
                            re_q    <= 1'b1;
                            raddr_q <= AW'(pack_addr(16'({1'b0, nxt_y_c} + nq_ext_c),
                                                     16'(nxt_x_c), COL_W));
                            state   <= RD_ISSUE;
                        end
                    end
                end
                FINISH: begin
                    if (!done_q) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        err_q  <= rej_q;
                    end else begin
                        done_q <= 1'b0;
                        err_q  <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.err   = err_q;
    assign bus.we    = we_q;
    assign bus.wdata = wdata_q;
    assign bus.waddr = AW'(pack_addr(16'(cur_y), 16'(cur_x), COL_W));
    assign bus.re    = re_q;
    assign bus.raddr = raddr_q;
endmodule

// File: tb/tb_vram_fill_scroll_engine.sv
// Scoreboard bench for vram_fill_scroll_engine with a latency-2 VRAM model.
module tb_vram_fill_scroll_engine;
    import vram_eng_pkg::*;

    localparam int unsigned COLS = 80, ROWS = 30, COL_W = 7, ROW_W = 5, DW = 8, RD_LAT = 2;
    localparam int unsigned AW = ROW_W + COL_W;

    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
    typedef struct { logic err; int lat; } dn_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    vram_fill_scroll_engine_if #(.COL_W(COL_W), .ROW_W(ROW_W), .DATA_W(DW)) bus();

    vram_fill_scroll_engine #(
        .COLS(COLS), .ROWS(ROWS), .COL_W(COL_W), .ROW_W(ROW_W), .DATA_W(DW), .RD_LAT(RD_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0, cyc = 0, start_cyc = 0, done_cnt = 0;
    wr_t         wq[$];
    dn_t         dq[$];
    logic [AW-1:0] rq[$];
    bit toggle = 1'b0, preload = 1'b0;
    logic [DW-1:0] mem [1 << AW];
    logic [DW-1:0] pipe [RD_LAT];

    function automatic logic [DW-1:0] src_val(input int y, input int x);
        return DW'(y * 5 + x + 1);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // VRAM model: write port plus RD_LAT-stage read pipeline
    always @(posedge clk) begin
        if (preload) begin
            for (int a = 0; a < (1 << AW); a++) mem[a] <= src_val(a >> COL_W, a % (1 << COL_W));
        end else if (bus.we && bus.wready && !rst) begin
            mem[bus.waddr] <= bus.wdata;
        end
        pipe[0] <= bus.re ? mem[bus.raddr] : 8'hEE;
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.rdata = pipe[RD_LAT-1];

    initial begin
        bus.wready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.wready = toggle ? ~bus.wready : 1'b1;
        end
    end

    // monitor: pops the scoreboard on every accepted write, read and done
    initial begin
        bit stall_q;
        logic [AW-1:0] st_addr;
        logic [DW-1:0] st_data;
        wr_t e;
        dn_t d;
        stall_q = 1'b0;
        st_addr = '0;
        st_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_q = 1'b0;
            end else begin
                if (stall_q) begin
                    chk("hold_we", 32'(bus.we), 32'(1));
                    chk("hold_waddr", 32'(bus.waddr), 32'(st_addr));
                    chk("hold_wdata", 32'(bus.wdata), 32'(st_data));
                end
                if (bus.we && bus.wready) begin
                    if (wq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL extra_write: got write at %0h expected none", bus.waddr);
                    end else begin
                        e = wq.pop_front();
                        chk("waddr", 32'(bus.waddr), 32'(e.addr));
                        chk("wdata", 32'(bus.wdata), 32'(e.data));
                    end
                end
                stall_q = bus.we && !bus.wready;
                st_addr = bus.waddr;
                st_data = bus.wdata;
                if (bus.re) begin
                    chk("re_with_we", 32'(bus.we), 32'(0));
                    if (rq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL extra_read: got read at %0h expected none", bus.raddr);
                    end else begin
                        chk("raddr", 32'(bus.raddr), 32'(rq.pop_front()));
                    end
                end
                if (bus.err && !bus.done) chk("err_without_done", 32'(bus.done), 32'(1));
                if (bus.done) begin
                    done_cnt++;
                    if (dq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL extra_done: got done at cycle %0d expected none", cyc);
                    end else begin
                        d = dq.pop_front();
                        chk("err", 32'(bus.err), 32'(d.err));
                        if (d.lat >= 0) chk("latency", 32'(cyc - start_cyc), 32'(d.lat));
                        chk("writes_left", 32'(wq.size()), 32'(0));
                        chk("reads_left", 32'(rq.size()), 32'(0));
                    end
                end
            end
        end
    end

    task automatic push_fill(input int xa, input int xb, input int ya, input int yb,
                             input logic [DW-1:0] f);
        for (int y = ya; y <= yb; y++)
            for (int x = xa; x <= xb; x++)
                wq.push_back('{addr: {ROW_W'(y), COL_W'(x)}, data: f});
    endtask

    task automatic push_scroll(input int n, input logic [DW-1:0] f);
        for (int y = 0; y <= int'(ROWS) - 1 - n; y++)
            for (int x = 0; x < int'(COLS); x++) begin
                wq.push_back('{addr: {ROW_W'(y), COL_W'(x)}, data: src_val(y + n, x)});
                rq.push_back({ROW_W'(y + n), COL_W'(x)});
            end
        push_fill(0, COLS - 1, ROWS - n, ROWS - 1, f);
    endtask

    task automatic push_done(input logic e, input int lat);
        dq.push_back('{err: e, lat: lat});
    endtask

    task automatic issue(input cmd_e c, input logic [DW-1:0] f, input int xa, input int xb,
                         input int ya, input int yb, input int n);
        @(posedge clk);
        #2;
        bus.cmd        = c;
        bus.fill_value = f;
        bus.x0         = COL_W'(xa);
        bus.x1         = COL_W'(xb);
        bus.y0         = ROW_W'(ya);
        bus.y1         = ROW_W'(yb);
        bus.scroll_n   = ROW_W'(n);
        bus.start      = 1'b1;
        start_cyc      = cyc;
        @(posedge clk);
        #2;
        bus.start      = 1'b0;
        bus.cmd        = 2'($urandom);
        bus.fill_value = DW'($urandom);
        bus.x0         = COL_W'($urandom);
        bus.x1         = COL_W'($urandom);
        bus.y0         = ROW_W'($urandom);
        bus.y1         = ROW_W'($urandom);
        bus.scroll_n   = ROW_W'($urandom);
        @(negedge clk);
        chk("busy_after_start", 32'(bus.busy), 32'(1));
    endtask

    task automatic wait_done(input int limit);
        int n0 = done_cnt;
        for (int i = 0; i < limit && done_cnt == n0; i++) @(negedge clk);
        chk("done_seen", 32'(done_cnt != n0), 32'(1));
    endtask

    initial begin
        int n0;
        bus.start = 1'b0; bus.cmd = '0; bus.fill_value = '0; bus.scroll_n = '0;
        bus.x0 = '0; bus.x1 = '0; bus.y0 = '0; bus.y1 = '0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'(0));
        chk("rst_done", 32'(bus.done), 32'(0));
        chk("rst_err", 32'(bus.err), 32'(0));
        chk("rst_we", 32'(bus.we), 32'(0));
        chk("rst_re", 32'(bus.re), 32'(0));
        chk("rst_waddr", 32'(bus.waddr), 32'(0));
        chk("rst_raddr", 32'(bus.raddr), 32'(0));
        chk("rst_wdata", 32'(bus.wdata), 32'(0));

        push_fill(0, 79, 0, 29, 8'h20); push_done(1'b0, 2401);
        issue(FULL_CLEAR, 8'h20, 0, 0, 0, 0, 0); wait_done(3000);

        push_fill(0, 79, 7, 7, 8'h41); push_done(1'b0, 81);
        issue(LINE_CLEAR, 8'h41, 0, 0, 7, 0, 0); wait_done(200);
        push_done(1'b1, 2);
        issue(LINE_CLEAR, 8'h41, 0, 0, 30, 0, 0); wait_done(20);

        toggle = 1'b1;
        push_fill(10, 12, 3, 4, 8'h2A); push_done(1'b0, -1);
        issue(RECT_FILL, 8'h2A, 10, 12, 3, 4, 0); wait_done(100);
        toggle = 1'b0;
        push_done(1'b1, 2);
        issue(RECT_FILL, 8'h2B, 12, 10, 3, 4, 0); wait_done(20);
        push_done(1'b1, 2);
        issue(RECT_FILL, 8'h2C, 0, 0, 0, 30, 0); wait_done(20);

        @(posedge clk); #2 preload = 1'b1;
        @(posedge clk); #2 preload = 1'b0;
        push_scroll(2, 8'h3C); push_done(1'b0, 9121);
        issue(SCROLL_UP, 8'h3C, 0, 0, 0, 0, 2); wait_done(12000);

        push_done(1'b0, 2);
        issue(SCROLL_UP, 8'h3D, 0, 0, 0, 0, 0); wait_done(20);
        push_fill(0, 79, 0, 29, 8'h07); push_done(1'b0, 2401);
        issue(SCROLL_UP, 8'h07, 0, 0, 0, 0, 31); wait_done(3000);

        push_fill(0, 19, 20, 21, 8'h66); push_done(1'b0, 41);
        issue(RECT_FILL, 8'h66, 0, 19, 20, 21, 0);
        repeat (4) @(posedge clk);
        #2 bus.cmd = FULL_CLEAR; bus.start = 1'b1;
        @(posedge clk);
        #2 bus.start = 1'b0;
        wait_done(200);

        push_fill(0, 79, 0, 9, 8'h55); push_done(1'b0, -1);
        issue(RECT_FILL, 8'h55, 0, 79, 0, 9, 0);
        repeat (20) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_we", 32'(bus.we), 32'(0));
        chk("midrst_re", 32'(bus.re), 32'(0));
        chk("midrst_busy", 32'(bus.busy), 32'(0));
        wq.delete(); dq.delete(); rq.delete();
        n0 = done_cnt;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("no_done_after_rst", 32'(done_cnt - n0), 32'(0));

        push_fill(0, 79, 29, 29, 8'h11); push_done(1'b0, 81);
        issue(LINE_CLEAR, 8'h11, 0, 0, 29, 0, 0); wait_done(200);
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
